rf_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (RegWrite/WR/WData) between two

---
 rtl/rf_wb_arbiter_if.sv | 34 +++
 rtl/rf_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU, load) and the register-file
// write arbiter, plus the pending-write scoreboard and idle status seen by decode.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                   req0_valid;
  logic                   req0_ready;
  logic [ADDR_W-1:0]      req0_wr;
  logic [DATA_W-1:0]      req0_wdata;
  logic                   req1_valid;
  logic                   req1_ready;
  logic [ADDR_W-1:0]      req1_wr;
  logic [DATA_W-1:0]      req1_wdata;
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_wr;
  logic [DATA_W-1:0]      rf_wdata;
  logic [2**ADDR_W-1:0]   pending;
  logic                   idle;

  modport master (
    output req0_valid, req0_wr, req0_wdata,
    output req1_valid, req1_wr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rf_we, rf_wr, rf_wdata, pending, idle
  );

  modport slave (
    input  req0_valid, req0_wr, req0_wdata,
    input  req1_valid, req1_wr, req1_wdata,
    output req0_ready, req1_ready,
    output rf_we, rf_wr, rf_wdata, pending, idle
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: two buffered writeback requesters share one
// registered write port round-robin; a per-register counter tracks in-flight writes.
module rf_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 2,
  parameter int ZERO_DISCARD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  rf_wb_arbiter_if.slave    bus
);
  localparam int NREG   = 2**ADDR_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PEND_W = $clog2(2*DEPTH + 2);

  typedef struct packed {
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wdata;
  } wb_req_t;

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  logic       in_valid [2];
  wb_req_t    in_req   [2];
  wb_req_t    mem      [2][DEPTH];
  logic [PTR_W-1:0] wptr [2];
  logic [PTR_W-1:0] rptr [2];
  logic [CNT_W-1:0] cnt  [2];
  logic       rdy  [2];
  logic       hv   [2];
  logic       push [2];
  logic       pop  [2];
  logic       gnt0, gnt1;
  wb_req_t    head;
  port_e      last_grant;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_wr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [PEND_W-1:0] pend_cnt [NREG];
  logic [NREG-1:0]   pending_v;

  assign in_valid[0] = bus.req0_valid;
  assign in_valid[1] = bus.req1_valid;
  assign in_req[0]   = {bus.req0_wr, bus.req0_wdata};
  assign in_req[1]   = {bus.req1_wr, bus.req1_wdata};

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every output of a combinational block is assigned before any condition, so no latches appear.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      rdy[n]  = (cnt[n] != CNT_W'(DEPTH));
      hv[n]   = (cnt[n] != '0);
      // Register-0 writes complete the handshake but never reach a FIFO.
      push[n] = in_valid[n] && rdy[n] && !((ZERO_DISCARD != 0) && (in_req[n].wr == '0));
    end
    gnt0   = hv[0] && (!hv[1] || (last_grant == PORT1));
    gnt1   = hv[1] && !gnt0;
    pop[0] = gnt0;
    pop[1] = gnt1;
    head   = gnt1 ? mem[1][rptr[1]] : mem[0][rptr[0]];
  end

  // NOTE: FIFO storage has no reset; a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) mem[n][wptr[n]] <= in_req[n];
    end
  end

  // NOTE: state uses <= so every register samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        wptr[n] <= '0;
        rptr[n] <= '0;
        cnt[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n]) wptr[n] <= next_ptr(wptr[n]);
        if (pop[n])  rptr[n] <= next_ptr(rptr[n]);
        case ({push[n], pop[n]})
          2'b10:   cnt[n] <= cnt[n] + 1'b1;
          2'b01:   cnt[n] <= cnt[n] - 1'b1;
          default: cnt[n] <= cnt[n];
        endcase
      end
    end
  end

  // last_grant starts at PORT1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_wr_q    <= '0;
      rf_wdata_q <= '0;
      last_grant <= PORT1;
    end else begin
      rf_we_q <= gnt0 || gnt1;
      if (gnt0 || gnt1) begin
        rf_wr_q    <= head.wr;
        rf_wdata_q <= head.wdata;
        last_grant <= gnt1 ? PORT1 : PORT0;
      end
    end
  end

  // A register stays pending from its enqueue edge through its commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) pend_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        pend_cnt[k] <= pend_cnt[k]
                     + PEND_W'(push[0] && (in_req[0].wr == ADDR_W'(k)))
                     + PEND_W'(push[1] && (in_req[1].wr == ADDR_W'(k)))
                     - PEND_W'(rf_we_q && (rf_wr_q == ADDR_W'(k)));
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NREG; k++) pending_v[k] = (pend_cnt[k] != '0);
  end

  assign bus.req0_ready = rdy[0];
  assign bus.req1_ready = rdy[1];
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_wr      = rf_wr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.pending    = pending_v;
  assign bus.idle       = !hv[0] && !hv[1] && !rf_we_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a queue-based model of the writeback rules.
module tb_rf_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;
  localparam int NREG   = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_DISCARD(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Reference model: one queue per requester, the granted write, and per-register in-flight counts.
  ent_t              q0[$];
  ent_t              q1[$];
  bit                m_we;
  logic [ADDR_W-1:0] m_wr;
  logic [DATA_W-1:0] m_wdata;
  bit                m_last;
  int                m_pend [NREG];
  bit                m_acc0, m_acc1;
  int                enq_cnt;
  int                dut_commits;
  int                hold1;

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_we    = 1'b0;
    m_wr    = '0;
    m_wdata = '0;
    m_last  = 1'b1;
    for (int k = 0; k < NREG; k++) m_pend[k] = 0;
    m_acc0 = 1'b1;
    m_acc1 = 1'b1;
  endtask

  // Applies one clock edge of the writeback rules using the inputs held across that edge.
  task automatic model_edge();
    bit   acc0, acc1;
    ent_t e;
    acc0 = bus.req0_valid && (q0.size() < DEPTH);
    acc1 = bus.req1_valid && (q1.size() < DEPTH);
    if (m_we) m_pend[m_wr] = m_pend[m_wr] - 1;
    if (q0.size() > 0 && (q1.size() == 0 || m_last == 1'b1)) begin
      e = q0.pop_front();
      m_we = 1'b1; m_wr = e.wr; m_wdata = e.data; m_last = 1'b0;
    end else if (q1.size() > 0) begin
      e = q1.pop_front();
      m_we = 1'b1; m_wr = e.wr; m_wdata = e.data; m_last = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (acc0 && bus.req0_wr != '0) begin
      e.wr = bus.req0_wr; e.data = bus.req0_wdata;
      q0.push_back(e);
      m_pend[e.wr] = m_pend[e.wr] + 1;
      enq_cnt++;
    end
    if (acc1 && bus.req1_wr != '0) begin
      e.wr = bus.req1_wr; e.data = bus.req1_wdata;
      q1.push_back(e);
      m_pend[e.wr] = m_pend[e.wr] + 1;
      enq_cnt++;
    end
    m_acc0 = acc0;
    m_acc1 = acc1;
  endtask

  // One clock: model follows the posedge, DUT outputs are compared at the negedge.
  task automatic step();
    logic [NREG-1:0] exp_pend;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < NREG; k++) exp_pend[k] = (m_pend[k] != 0);
    if (bus.rf_we === 1'b1) dut_commits++;
    checks++;
    if (bus.rf_we !== m_we) begin
      failures++;
      $display("FAIL model_rf_we t=%0t got=%b exp=%b", $time, bus.rf_we, m_we);
    end
    if (m_we) begin
      checks++;
      if (bus.rf_wr !== m_wr || bus.rf_wdata !== m_wdata) begin
        failures++;
        $display("FAIL model_rf_data t=%0t got=%0d/%h exp=%0d/%h",
                 $time, bus.rf_wr, bus.rf_wdata, m_wr, m_wdata);
      end
    end
    checks++;
    if (bus.pending !== exp_pend) begin
      failures++;
      $display("FAIL model_pending t=%0t got=%h exp=%h", $time, bus.pending, exp_pend);
    end
    checks++;
    if (bus.idle !== (q0.size() == 0 && q1.size() == 0 && !m_we)) begin
      failures++;
      $display("FAIL model_idle t=%0t got=%b", $time, bus.idle);
    end
    checks++;
    if (bus.req0_ready !== (q0.size() < DEPTH) || bus.req1_ready !== (q1.size() < DEPTH)) begin
      failures++;
      $display("FAIL model_ready t=%0t got=%b%b exp=%b%b", $time, bus.req0_ready,
               bus.req1_ready, q0.size() < DEPTH, q1.size() < DEPTH);
    end
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_wr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_wr = '0; bus.req1_wdata = '0;
  endtask

  // Random requests that respect the handshake: an unaccepted request is held unchanged.
  task automatic drive_random(input int pct, input bit nonzero);
    if (!(bus.req0_valid && !m_acc0)) begin
      bus.req0_valid = ($urandom_range(0, 99) < pct);
      bus.req0_wr    = nonzero ? ADDR_W'($urandom_range(1, 31)) : ADDR_W'($urandom_range(0, 31));
      bus.req0_wdata = $urandom;
    end
    if (bus.req1_valid && !m_acc1) begin
      hold1++;
    end else begin
      bus.req1_valid = ($urandom_range(0, 99) < pct);
      bus.req1_wr    = nonzero ? ADDR_W'($urandom_range(1, 31)) : ADDR_W'($urandom_range(0, 31));
      bus.req1_wdata = $urandom;
    end
  endtask

  task automatic drain();
    int n;
    clear_inputs();
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_we) && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL drain_timeout q0=%0d q1=%0d", q0.size(), q1.size());
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.rf_we !== 1'b0 || bus.pending !== '0 || bus.idle !== 1'b1 ||
        bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_initial we=%b pend=%h idle=%b rdy=%b%b", bus.rf_we, bus.pending,
               bus.idle, bus.req0_ready, bus.req1_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_random(100, 1'b1);
      step();
    end
    checks++;
    if (!m_we) begin
      failures++;
      $display("FAIL reset_burst_setup got=%b exp=1", m_we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rf_we !== 1'b0 || bus.pending !== '0 || bus.idle !== 1'b1 ||
        bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_midburst we=%b pend=%h idle=%b rdy=%b%b", bus.rf_we, bus.pending,
               bus.idle, bus.req0_ready, bus.req1_ready);
    end
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1; bus.req0_wr = 5'd5; bus.req0_wdata = 32'hDEADBEEF;
    step();
    bus.req0_valid = 1'b0;
    checks++;
    if (bus.pending[5] !== 1'b1 || bus.rf_we !== 1'b0) begin
      failures++;
      $display("FAIL single_e0 pend5=%b we=%b exp=1,0", bus.pending[5], bus.rf_we);
    end
    step();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd5 || bus.rf_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_e1 we=%b wr=%0d data=%h exp=1,5,deadbeef", bus.rf_we, bus.rf_wr,
               bus.rf_wdata);
    end
    step();
    checks++;
    if (bus.pending[5] !== 1'b0 || bus.rf_we !== 1'b0) begin
      failures++;
      $display("FAIL single_e2 pend5=%b we=%b exp=0,0", bus.pending[5], bus.rf_we);
    end
  endtask

  task automatic test_contention();
    int i0, i1, ng;
    bit saw_full0, saw_full1;
    do_reset();
    i0 = 0; i1 = 0; ng = 0;
    saw_full0 = 1'b0; saw_full1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.req0_valid = (i0 < 4); bus.req0_wr = ADDR_W'(1 + i0); bus.req0_wdata = $urandom;
      bus.req1_valid = (i1 < 4); bus.req1_wr = ADDR_W'(9 + i1); bus.req1_wdata = $urandom;
      step();
      if (m_acc0 && i0 < 4) i0++;
      if (m_acc1 && i1 < 4) i1++;
      if (bus.req0_ready === 1'b0) saw_full0 = 1'b1;
      if (bus.req1_ready === 1'b0) saw_full1 = 1'b1;
      if (bus.rf_we === 1'b1 && ng < 8) begin
        checks++;
        if ((bus.rf_wr >= 5'd9) !== ng[0]) begin
          failures++;
          $display("FAIL contention_order grant%0d got_port=%0d exp_port=%0d", ng,
                   bus.rf_wr >= 5'd9, ng % 2);
        end
        ng++;
      end
    end
    checks++;
    if (ng != 8 || !saw_full0 || !saw_full1) begin
      failures++;
      $display("FAIL contention_summary grants=%0d full0=%b full1=%b exp=8,1,1", ng,
               saw_full0, saw_full1);
    end
    clear_inputs();
  endtask

  task automatic test_raw_count();
    drain();
    bus.req0_valid = 1'b1; bus.req0_wr = 5'd7; bus.req0_wdata = 32'h0000_0A0A;
    bus.req1_valid = 1'b1; bus.req1_wr = 5'd7; bus.req1_wdata = 32'h0000_0B0B;
    step();
    clear_inputs();
    checks++;
    if (bus.pending[7] !== 1'b1 || m_pend[7] != 2) begin
      failures++;
      $display("FAIL raw_enqueue pend7=%b model_cnt=%0d exp=1,2", bus.pending[7], m_pend[7]);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (bus.pending[7] !== (c < 3)) begin
        failures++;
        $display("FAIL raw_cycle%0d pend7 got=%b exp=%b", c, bus.pending[7], c < 3);
      end
    end
  endtask

  task automatic test_zero();
    int we_seen;
    drain();
    bus.req1_valid = 1'b1; bus.req1_wr = '0; bus.req1_wdata = 32'h0000_1234;
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_ready got=%b exp=1", bus.req1_ready);
    end
    step();
    clear_inputs();
    checks++;
    if (bus.idle !== 1'b1 || bus.pending[0] !== 1'b0) begin
      failures++;
      $display("FAIL zero_accept idle=%b pend0=%b exp=1,0", bus.idle, bus.pending[0]);
    end
    we_seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.rf_we !== 1'b0 || bus.pending[0] !== 1'b0) we_seen++;
    end
    checks++;
    if (we_seen != 0) begin
      failures++;
      $display("FAIL zero_never_written bad_cycles=%0d exp=0", we_seen);
    end
  endtask

  task automatic test_backpressure();
    drain();
    enq_cnt     = 0;
    dut_commits = 0;
    hold1       = 0;
    for (int c = 0; c < 300; c++) begin
      drive_random(85, 1'b0);
      step();
    end
    drain();
    checks++;
    if (hold1 < 3) begin
      failures++;
      $display("FAIL backpressure_holds got=%0d exp>=3", hold1);
    end
    checks++;
    if (dut_commits != enq_cnt) begin
      failures++;
      $display("FAIL backpressure_conservation commits=%0d exp=%0d", dut_commits, enq_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_raw_count();
    test_zero();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "bench did not finish");
  end
endmodule
